adler32_core: RTL and testbench
===============================

Name: adler32_core

Overview:
- Upstream stage of the zlib/PNG compressor. It computes the Adler-32 checksum (RFC 1950) over the uncompressed byte stream, in parallel with the LZ77 stage consuming the same bytes.
- Delivers the final 32-bit checksum with a one-cycle done pulse to the bitstream top's adler32_done_i / adler32_dat_i inputs.
- The checksum must be ready before the bitstream top enters its ADLER32 state. That state comes at least 4 cycles after the LZ77 last symbol, so the latency budget is small.

Parameters:
- DATA_WD, 32, checksum width (fixed; s2 in [31:16], s1 in [15:0]).
- BYTE_WD, 8, input byte width.
- MOD_BASE, 65521, Adler-32 modulus (largest prime below 2^16).
- CNT_WD, 32, width of processed-byte counter.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse; begins a new stream, s1:=1, s2:=0.
- val_i  input  1  dat_i carries a valid byte this cycle.
- dat_i  input  8  uncompressed data byte.
- lst_i  input  1  qualified by val_i; marks the final byte of the stream.
- done_o  output  1  one-cycle pulse; dat_o is valid and final.
- dat_o  output  32  checksum {s2,s1}; held until the next start_i.
- cnt_o  output  32  number of bytes accumulated in the current/last stream.
- err_o  output  1  sticky; val_i seen while IDLE or DONE; cleared by start_i.

Behaviour:
- Reset values: done_o=0, dat_o=32'h0000_0001 (s1=1, s2=0), cnt_o=0, err_o=0, state=IDLE.
- FSM, 2 bits, three states:
  - IDLE: start_i -> BUSY (s1:=1, s2:=0, cnt:=0, err:=0).
  - BUSY: each val_i byte is accumulated. If val_i&&lst_i -> DONE.
  - DONE: lasts exactly 1 cycle; done_o=1 -> IDLE.
- Accumulate, in a single cycle per byte (1 byte/clk throughput, no back-pressure):
  - t1 = s1 + dat_i (17 bit); s1n = t1 >= MOD_BASE ? t1 - MOD_BASE : t1.
  - t2 = s2 + s1n (17 bit); s2n = t2 >= MOD_BASE ? t2 - MOD_BASE : t2.
  - One conditional subtract suffices for each: s1 < 65521 and dat_i <= 255 give t1 < 2*65521; s2 and s1n are both < 65521, so t2 < 2*65521.
- dat_o is registered {s2,s1} and updates every accepted byte. It is only guaranteed final while done_o=1 and afterwards.
- Latency: done_o rises in the cycle immediately after the clock edge that accepted the lst_i byte (1 cycle), well inside the 4-cycle window downstream.
- cnt_o increments on every accepted byte and wraps modulo 2^CNT_WD without flagging.
- Boundary conditions:
  - start_i while BUSY: abandon the current stream and restart accumulation (s1:=1, s2:=0, cnt:=0). No done_o for the abandoned stream.
  - start_i and val_i in the same cycle: start takes effect and the byte is accumulated onto the fresh state (result = Adler of that byte), so a single-byte stream is start_i+val_i+lst_i in one cycle.
  - start_i in the DONE cycle: done_o still pulses this cycle; next state is BUSY with the fresh state.
  - val_i in IDLE/DONE without start_i: byte ignored, err_o:=1, checksum unchanged.
  - lst_i without val_i: ignored.
  - Empty stream is not supported (the compressor never emits one).
  - Reset mid-stream: all registers return to reset values immediately (async); no done_o.

Decomposition:
- Shared package/defines: ADLER_MOD=65521 and ADLER_INIT=32'h0000_0001, reused by the bench reference model and any future multi-byte variant.
- One natural sub-module, adler32_modadd: a combinational a+b with conditional subtract of MOD_BASE (16-bit a, 16-bit b, 16-bit result). It is instantiated twice, for s1 and s2, in series.
- FSM, registers and counters stay in the top.

Test Plan:
- start_i+val_i+lst_i, dat_i=8'h61 ("a") in one cycle -> done_o next cycle, dat_o=32'h0062_0062, cnt_o=1.
- start, then "abc" on 3 consecutive cycles, lst on 'c' -> dat_o=32'h024D_0127, cnt_o=3, done_o one cycle only.
- "Wikipedia" with val_i gaps (random idle cycles between bytes) -> dat_o=32'h11E6_0398, cnt_o=9.
- 258 bytes of 8'hFF back-to-back (exercises the s1 and s2 wrap) -> dat_o=32'h091D_010E, cnt_o=258.
- Restart and error cases:
  - start, "xyz" without lst, then start+"abc"+lst -> only one done_o, dat_o=32'h024D_0127.
  - val_i in IDLE -> err_o=1, dat_o unchanged; next start_i clears err_o.
- rstn low after 5 bytes -> dat_o=32'h0000_0001, cnt_o=0, done_o=0, state IDLE.
- Back-to-back streams, start_i during the DONE cycle -> both checksums correct and both done_o pulses present.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared Adler-32 constants and FSM encoding for the checksum core and its reference model.
package adler32_pkg;

    localparam int unsigned DATA_WD  = 32;
    localparam int unsigned BYTE_WD  = 8;
    localparam int unsigned CNT_WD   = 32;
    localparam int unsigned SUM_WD   = 16;
    localparam int unsigned MOD_BASE = 65521;

    // Modulus widened to hold the un-reduced sum of two 16-bit residues.
    localparam logic [SUM_WD:0]     ADLER_MOD  = 17'd65521;
    localparam logic [DATA_WD-1:0]  ADLER_INIT = 32'h0000_0001;
    localparam logic [CNT_WD-1:0]   CNT_ONE    = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adler32_modadd.sv
// Combinational (a + b) mod 65521 for operands already below the modulus.
module adler32_modadd
    import adler32_pkg::*;
(
    input  logic [SUM_WD-1:0] i_a,
    input  logic [SUM_WD-1:0] i_b,
    output logic [SUM_WD-1:0] o_y
);

    logic [SUM_WD:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Both operands are below the modulus, so the sum is below twice it: one subtract is enough.
    assign o_y = (w_sum >= ADLER_MOD) ? SUM_WD'(w_sum - ADLER_MOD) : w_sum[SUM_WD-1:0];

endmodule

// File: rtl/adler32_core.sv
// Byte-serial Adler-32 checksum, one byte per clock, with a one-cycle done pulse after the last byte.
module adler32_core
    import adler32_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic                val_i,
    input  logic [BYTE_WD-1:0]  dat_i,
    input  logic                lst_i,
    output logic                done_o,
    output logic [DATA_WD-1:0]  dat_o,
    output logic [CNT_WD-1:0]   cnt_o,
    output logic                err_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SUM_WD-1:0]   r_s1;
    logic [SUM_WD-1:0]   r_s2;
    logic [CNT_WD-1:0]   r_cnt;
    logic                r_err;

    logic [SUM_WD-1:0]   w_s1_base;
    logic [SUM_WD-1:0]   w_s2_base;
    logic [CNT_WD-1:0]   w_cnt_base;
    logic [SUM_WD-1:0]   w_s1_nxt;
    logic [SUM_WD-1:0]   w_s2_nxt;
    logic                w_acc;

    // A start in the same cycle as a byte accumulates that byte onto the fresh state.
    assign w_s1_base  = start_i ? ADLER_INIT[SUM_WD-1:0]      : r_s1;
    assign w_s2_base  = start_i ? ADLER_INIT[DATA_WD-1:SUM_WD] : r_s2;
    assign w_cnt_base = start_i ? '0                           : r_cnt;
    assign w_acc      = val_i && (start_i || (r_state == ST_BUSY));

    adler32_modadd u_add_s1 (
        .i_a (w_s1_base),
        .i_b ({{(SUM_WD-BYTE_WD){1'b0}}, dat_i}),
        .o_y (w_s1_nxt)
    );

    adler32_modadd u_add_s2 (
        .i_a (w_s2_base),
        .i_b (w_s1_nxt),
        .o_y (w_s2_nxt)
    );

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
        w_state_nxt = r_state;
        if (w_acc && lst_i) begin
            w_state_nxt = ST_DONE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (start_i) w_state_nxt = ST_BUSY;
                ST_BUSY: w_state_nxt = ST_BUSY;
                ST_DONE: w_state_nxt = start_i ? ST_BUSY : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_s1    <= ADLER_INIT[SUM_WD-1:0];
            r_s2    <= ADLER_INIT[DATA_WD-1:SUM_WD];
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_s1  <= w_s1_nxt;
                r_s2  <= w_s2_nxt;
                r_cnt <= w_cnt_base + CNT_ONE;
            end else if (start_i) begin
                r_s1  <= w_s1_base;
                r_s2  <= w_s2_base;
                r_cnt <= w_cnt_base;
            end
            if (start_i) begin
                r_err <= 1'b0;
            end else if (val_i && (r_state != ST_BUSY)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign done_o = (r_state == ST_DONE);
    assign dat_o  = {r_s2, r_s1};
    assign cnt_o  = r_cnt;
    assign err_o  = r_err;

endmodule

// File: tb/tb_adler32_core.sv
// Scoreboard bench for adler32_core: expected checksums queued at the last byte, compared on done_o.
module tb_adler32_core;
    import adler32_pkg::*;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [31:0] dat;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic        val_i;
    logic [7:0]  dat_i;
    logic        lst_i;
    logic        done_o;
    logic [31:0] dat_o;
    logic [31:0] cnt_o;
    logic        err_o;

    exp_t sb[$];
    int   n_vec;
    int   n_mis;

    adler32_core dut (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (start_i),
        .val_i   (val_i),
        .dat_i   (dat_i),
        .lst_i   (lst_i),
        .done_o  (done_o),
        .dat_o   (dat_o),
        .cnt_o   (cnt_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Independent reference using full modulo reduction.
    function automatic logic [31:0] adler_ref(input byte_q_t data);
        int unsigned s1 = 1;
        int unsigned s2 = 0;
        foreach (data[i]) begin
            s1 = (s1 + data[i]) % MOD_BASE;
            s2 = (s2 + s1) % MOD_BASE;
        end
        return {s2[15:0], s1[15:0]};
    endfunction

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    always @(negedge clk) begin
        if (rstn && done_o) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_dat", dat_o, e.dat);
                check("done_cnt", cnt_o, e.cnt);
            end
        end
    end

    task automatic drive(input logic s, input logic v, input logic l, input logic [7:0] d);
        @(negedge clk);
        start_i = s;
        val_i   = v;
        lst_i   = l;
        dat_i   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Sends one stream; the expected result is queued as the last byte is driven.
    task automatic run_stream(input byte_q_t data, input logic merged, input int max_gap,
                              input logic [31:0] exp_dat, input logic with_lst);
        exp_t e;
        if (!merged) drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < data.size(); i++) begin
            if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
            if (with_lst && i == data.size() - 1) begin
                e.dat = exp_dat;
                e.cnt = data.size();
                sb.push_back(e);
            end
            drive(merged && i == 0, 1'b1, with_lst && i == data.size() - 1, data[i]);
        end
    endtask

    task automatic drain(input string tag);
        int budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        byte_q_t q;
        byte_q_t q2;
        n_vec   = 0;
        n_mis   = 0;
        rstn    = 1'b0;
        start_i = 1'b0;
        val_i   = 1'b0;
        lst_i   = 1'b0;
        dat_i   = 8'h00;
        #23;
        check("rst_dat", dat_o, 32'h0000_0001);
        check("rst_cnt", cnt_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        q = str2q("a");
        run_stream(q, 1'b1, 0, 32'h0062_0062, 1'b1);
        idle(1);
        drain("single_byte");

        q = str2q("abc");
        run_stream(q, 1'b0, 0, 32'h024D_0127, 1'b1);
        idle(3);
        drain("abc");

        q = str2q("Wikipedia");
        run_stream(q, 1'b0, 3, 32'h11E6_0398, 1'b1);
        idle(2);
        drain("wikipedia");

        q.delete();
        for (int i = 0; i < 258; i++) q.push_back(8'hFF);
        run_stream(q, 1'b0, 0, 32'h091D_010E, 1'b1);
        idle(2);
        drain("ff_wrap");

        // Abandoned stream must not produce a done pulse.
        q = str2q("xyz");
        run_stream(q, 1'b0, 0, 32'h0, 1'b0);
        q = str2q("abc");
        run_stream(q, 1'b0, 0, 32'h024D_0127, 1'b1);
        idle(3);
        drain("restart");

        drive(1'b0, 1'b1, 1'b0, 8'h55);
        idle(1);
        check("idle_err_set", err_o, 1);
        check("idle_dat_hold", dat_o, 32'h024D_0127);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        idle(1);
        check("start_err_clr", err_o, 0);
        check("start_fresh", dat_o, 32'h0000_0001);

        q = str2q("hello");
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, q[i]);
        idle(1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_dat", dat_o, 32'h0000_0001);
        check("midrst_cnt", cnt_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_err", err_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h11);
        idle(1);
        check("midrst_idle", err_o, 1);

        // Second stream's start lands in the first stream's DONE cycle.
        q  = str2q("abc");
        q2 = str2q("Wikipedia");
        run_stream(q, 1'b0, 0, 32'h024D_0127, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("b2b_done_at_start", done_o, 1);
        run_stream(q2, 1'b0, 0, 32'h11E6_0398, 1'b1);
        idle(3);
        drain("b2b");

        for (int n = 0; n < 6; n++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(1, 40); i++) q.push_back(8'($urandom));
            run_stream(q, n[0], 2, adler_ref(q), 1'b1);
        end
        idle(3);
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
